mult_hilo_ctrl: RTL and testbench

- Sequencing and arbitration controller for the shared 64-iteration shift-add multiplier in the execute stage.
- Accepts MULT/MULTU requests from the two issue pipes and grants one at a time.
- Drives the multiplier's one-cycle start pulse and operands, counts its iterations, and commits the 64-bit product into the architectural HI/LO registers.
- Exposes a busy flag so the issue logic stalls MFHI/MFLO and further multiplies.

---
 rtl/mult_hilo_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mult_hilo_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_ctrl.sv
// rtl/mult_hilo_ctrl.sv - sequencing/arbitration controller for the shared shift-add multiplier
//
// Accepts MULT/MULTU requests from two issue pipes, grants one at a time,
// launches the external multiplier with a one-cycle start pulse, counts its
// iterations and commits the 64-bit product into the architectural HI/LO.
//
// Optional feature macro: MULT_RR_EN
//   defined   : round-robin arbitration between the two pipes
//   undefined : fixed priority, pipe 0 wins ties
//
// Parameters:
//   ITERS        multiplier shift iterations after the load edge
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/_signed     request and MULT(1)/MULTU(0) select per pipe
//   req{0,1}_a/_b              32-bit operands per pipe
//   req{0,1}_ready             combinational grant (transfer on valid & ready)
//   flush                      abort any in-flight multiply
//   mul_start/_signed/_a/_b    registered launch controls to the multiplier
//   mul_s                      64-bit multiplier product
//   hi, lo                     architectural HI/LO
//   busy                       accept edge until HI/LO are written
//   done, done_src             one-cycle completion pulse and requester index

module mult_hilo_ctrl #(
    parameter int ITERS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req0_signed,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_signed,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    input  logic        flush,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_s,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        done_src
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             src_q;
    logic             mul_start_q;
    logic             mul_signed_q;
    logic [31:0]      mul_a_q;
    logic [31:0]      mul_b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             busy_q;
    logic             done_q;
    logic             done_src_q;

    logic             can_grant;
    logic             pick0;
    logic             accept0;
    logic             accept1;

    // Grants are only offered while idle and not being flushed.
    assign can_grant = (state_q == S_IDLE) && !flush;

`ifdef MULT_RR_EN
    // ptr_q names the preferred pipe on a tie; a lone requester always wins.
    logic ptr_q;
    assign pick0 = req0_valid ? (!req1_valid || !ptr_q) : !req1_valid;
`else
    assign pick0 = req0_valid || !req1_valid;
`endif

    // pick0 steers the single grant so at most one ready is ever high.
    assign req0_ready = can_grant && pick0;
    assign req1_ready = can_grant && !pick0;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            src_q        <= 1'b0;
            mul_start_q  <= 1'b0;
            mul_signed_q <= 1'b0;
            mul_a_q      <= 32'd0;
            mul_b_q      <= 32'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_src_q   <= 1'b0;
`ifdef MULT_RR_EN
            ptr_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (flush && (state_q != S_IDLE)) begin
                // Abort: HI/LO untouched, no done pulse; operands keep their values.
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                mul_start_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept0 || accept1) begin
                            mul_a_q      <= accept1 ? req1_a : req0_a;
                            mul_b_q      <= accept1 ? req1_b : req0_b;
                            mul_signed_q <= accept1 ? req1_signed : req0_signed;
                            mul_start_q  <= 1'b1;
                            src_q        <= accept1;
                            busy_q       <= 1'b1;
                            state_q      <= S_START;
`ifdef MULT_RR_EN
                            ptr_q        <= ~accept1;
`endif
                        end
                    end
                    S_START: begin
                        // Multiplier loads on this edge; iterations begin next cycle.
                        mul_start_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_RUN;
                    end
                    S_RUN: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        hi_q       <= mul_s[63:32];
                        lo_q       <= mul_s[31:0];
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        done_src_q <= src_q;
                        state_q    <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mul_start  = mul_start_q;
    assign mul_signed = mul_signed_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_src   = done_src_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb/tb_mult_hilo_ctrl.sv - self-checking bench for mult_hilo_ctrl

module tb_mult_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_signed = 1'b0, req1_signed = 1'b0;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic        req0_ready, req1_ready;
    logic        flush = 1'b0;
    logic        mul_start, mul_signed;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_s = 64'd0;
    logic [31:0] hi, lo;
    logic        busy, done, done_src;

    always #5 clk = ~clk;

    mult_hilo_ctrl #(.ITERS(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_signed(req0_signed), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_signed(req1_signed), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .flush(flush),
        .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .done_src(done_src)
    );

    // Stand-in multiplier: loads on the start edge, presents the product only
    // after 64 further edges, and shows junk before that.
    function automatic logic [63:0] ext_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    logic [63:0] m_prod = 64'd0;
    int          m_it = 0;
    logic        m_run = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            m_prod <= ext_mul(mul_signed, mul_a, mul_b);
            mul_s  <= 64'hDEAD_BEEF_DEAD_BEEF;
            m_it   <= 0;
            m_run  <= 1'b1;
        end else if (m_run) begin
            m_it <= m_it + 1;
            if (m_it == 63) begin
                mul_s <= m_prod;
                m_run <= 1'b0;
            end
        end
    end

    typedef struct packed {
        logic        src;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct packed {
        logic        src;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    exp_t        sb[$];
    int          grants[$];
    logic [31:0] exp_hi0 = 32'd0, exp_lo0 = 32'd0, exp_hi1 = 32'd0, exp_lo1 = 32'd0;
    logic        multi_ready = 1'b0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept monitor: pushes the expected result for whichever pipe transfers.
    always @(posedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (req0_ready && req1_ready) multi_ready <= 1'b1;
            if (req0_valid && req0_ready) begin
                e.src = 1'b0; e.hi = exp_hi0; e.lo = exp_lo0;
                sb.push_back(e);
                grants.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                e.src = 1'b1; e.hi = exp_hi1; e.lo = exp_lo1;
                sb.push_back(e);
                grants.push_back(1);
            end
        end
    end

    // Completion monitor: pops and compares on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: done=1 with no pending multiply, expected done=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_src", {63'd0, done_src}, {63'd0, e.src});
                check("hi", {32'd0, hi}, {32'd0, e.hi});
                check("lo", {32'd0, lo}, {32'd0, e.lo});
            end
        end
    end

    // Called at a negedge in IDLE: drives the request and confirms the grant.
    task automatic start_req(input logic src, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ehi, input logic [31:0] elo);
        if (src) begin
            req1_valid = 1'b1; req1_signed = sgn; req1_a = a; req1_b = b; exp_hi1 = ehi; exp_lo1 = elo;
        end else begin
            req0_valid = 1'b1; req0_signed = sgn; req0_a = a; req0_b = b; exp_hi0 = ehi; exp_lo0 = elo;
        end
        #1;
        check("ready_granted", {63'd0, (src ? req1_ready : req0_ready)}, 64'd1);
    endtask

    // Current cycle is the accept cycle (cycle 0); counts cycles up to done.
    task automatic wait_done(input string name);
        int n;
        bit busy_ok, start_ok;
        busy_ok = 1'b1;
        start_ok = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (mul_start != (n == 1)) start_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'd67);
        check({name, "_busy_window"}, {63'd0, busy_ok}, 64'd1);
        check({name, "_start_pulse"}, {63'd0, start_ok}, 64'd1);
        check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b0, 32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A};
        vecs[1] = '{1'b1, 1'b1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001};
        vecs[4] = '{1'b0, 1'b1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b1, 32'h7FFF_FFFF,  32'h8000_0000,  32'hC000_0000, 32'h8000_0000};
        vecs[6] = '{1'b0, 1'b0, 32'h0001_0000,  32'h0001_0000,  32'h0000_0001, 32'h0000_0000};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_mul_start", {63'd0, mul_start}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention: both pipes valid until four multiplies are accepted
        grants.delete();
        req0_signed = 1'b0; req0_a = 32'd2; req0_b = 32'd3; exp_hi0 = 32'd0; exp_lo0 = 32'd6;
        req1_signed = 1'b0; req1_a = 32'd5; req1_b = 32'd7; exp_hi1 = 32'd0; exp_lo1 = 32'd35;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        while (grants.size() < 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("cont_grant_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) begin
`ifdef MULT_RR_EN
                check("cont_grant_rr", 64'(grants[i]), 64'(i % 2));
`else
                check("cont_grant_fixed", 64'(grants[i]), 64'd0);
`endif
            end
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cont_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);

        // Table-driven single multiplies
        for (int i = 0; i < NV; i++) begin
            start_req(vecs[i].src, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            wait_done("vec");
            check("hold_mul_a", {32'd0, mul_a}, {32'd0, vecs[i].a});
            check("hold_mul_b", {32'd0, mul_b}, {32'd0, vecs[i].b});
            check("hold_mul_signed", {63'd0, mul_signed}, {63'd0, vecs[i].sgn});
        end

        // Flush at cycle 30 with prior HI/LO = 0x11/0x22
        start_req(1'b0, 1'b0, 32'h22, 32'h8000_0001, 32'h11, 32'h22);
        wait_done("prime");
        start_req(1'b0, 1'b0, 32'h10, 32'h10, 32'h0, 32'h100);
        @(negedge clk);
        req0_valid = 1'b0;
        n = 1;
        while (n < 30) begin
            @(negedge clk);
            n++;
        end
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        #1;
        check("flush_busy_c31", {63'd0, busy}, 64'd0);
        check("flush_no_done", {63'd0, done}, 64'd0);
        check("flush_hi_kept", {32'd0, hi}, 64'h11);
        check("flush_lo_kept", {32'd0, lo}, 64'h22);
        start_req(1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);
        wait_done("after_flush");

        // Asynchronous reset mid-RUN
        start_req(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (39) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hi", {32'd0, hi}, 64'd0);
        check("arst_lo", {32'd0, lo}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done_src", {63'd0, done_src}, 64'd0);
        check("arst_mul_start", {63'd0, mul_start}, 64'd0);
        check("arst_mul_signed", {63'd0, mul_signed}, 64'd0);
        check("arst_mul_a", {32'd0, mul_a}, 64'd0);
        check("arst_mul_b", {32'd0, mul_b}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_req(1'b0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd9);
        wait_done("post_reset");

        check("one_ready_per_cycle", {63'd0, multi_ready}, 64'd0);
        check("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
